// File: rtl/z80fi_trace_gen.sv
// ---------------------------------------------------------------------------
// z80fi_trace_gen
//
// Producer side of the Z80FI formal interface. Watches the core's
// instruction boundaries and bus events. It builds a working record for the
// open instruction and publishes one trace record per retired instruction.
// The record is published through registered outputs, together with a
// one-cycle o_z80fi_valid strobe.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_insn_start            core begins an instruction (first M1) this cycle
//   i_insn_done             core retires the open instruction this cycle
//   i_core_regs[209:0]      live architectural state, packed MSB-first:
//                           ip, a,f,b,c,d,e,h,l, a2..l2, ix,iy,sp, i,r,
//                           iff1,iff2
//   i_bus_evt_*             completed bus transaction (valid/kind/addr/data)
//                           kind: 0 fetch, 1 mem rd, 2 mem wr, 3 io rd,
//                           4 io wr, 5-7 ignored
//   o_z80fi_valid           one-cycle strobe, record outputs are fresh
//   o_z80fi_order           retire count of this record (wraps)
//   o_z80fi_regs_in/out     state at i_insn_start / at i_insn_done
//   o_z80fi_insn/_insn_len  fetched bytes (first in [7:0]) and their count
//   o_mem_rd/2, o_mem_wr/2, o_io_rd, o_io_wr      slot-used flags
//   o_bus_raddr/2, o_bus_rdata/2                  read slots 1/2
//   o_bus_waddr/2, o_bus_wdata/2                  write slots 1/2
//   o_z80fi_error           a slot or the byte buffer overflowed
// ---------------------------------------------------------------------------
module z80fi_trace_gen #(
    parameter int MAX_INSN_BYTES = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_insn_start,
    input  logic          i_insn_done,
    input  logic [209:0]  i_core_regs,
    input  logic          i_bus_evt_valid,
    input  logic [2:0]    i_bus_evt_kind,
    input  logic [15:0]   i_bus_evt_addr,
    input  logic [7:0]    i_bus_evt_data,
    output logic          o_z80fi_valid,
    output logic [15:0]   o_z80fi_order,
    output logic [209:0]  o_z80fi_regs_in,
    output logic [209:0]  o_z80fi_regs_out,
    output logic [31:0]   o_z80fi_insn,
    output logic [2:0]    o_z80fi_insn_len,
    output logic          o_mem_rd,
    output logic          o_mem_rd2,
    output logic          o_mem_wr,
    output logic          o_mem_wr2,
    output logic          o_io_rd,
    output logic          o_io_wr,
    output logic [15:0]   o_bus_raddr,
    output logic [15:0]   o_bus_raddr2,
    output logic [15:0]   o_bus_waddr,
    output logic [15:0]   o_bus_waddr2,
    output logic [7:0]    o_bus_rdata,
    output logic [7:0]    o_bus_rdata2,
    output logic [7:0]    o_bus_wdata,
    output logic [7:0]    o_bus_wdata2,
    output logic          o_z80fi_error
);

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    // Transaction part of a record: everything that bus events can modify.
    typedef struct packed {
        logic        mem_rd;
        logic        mem_rd2;
        logic        mem_wr;
        logic        mem_wr2;
        logic        io_rd;
        logic        io_wr;
        logic [15:0] raddr;
        logic [15:0] raddr2;
        logic [15:0] waddr;
        logic [15:0] waddr2;
        logic [7:0]  rdata;
        logic [7:0]  rdata2;
        logic [7:0]  wdata;
        logic [7:0]  wdata2;
        logic [31:0] insn;
        logic [2:0]  len;
        logic        err;
    } rec_t;

    localparam rec_t REC_ZERO = '0;

    // Folds one bus event into a record. Read/write slot 1 is shared between
    // memory and I/O: a memory access falls through to slot 2 when slot 1 is
    // taken. An I/O access has no second slot, so a conflict only flags the
    // error.
    function automatic rec_t apply_evt(input rec_t       rec_in,
                                       input logic [2:0] kind,
                                       input logic [15:0] addr,
                                       input logic [7:0]  data);
        rec_t rec;
        rec = rec_in;
        case (kind)
            3'd0: begin
                if (rec.len < 3'(MAX_INSN_BYTES)) begin
                    rec.insn[{rec.len[1:0], 3'b000} +: 8] = data;
                    rec.len = rec.len + 3'd1;
                end else begin
                    rec.err = 1'b1;
                end
            end
            3'd1: begin
                if (!(rec.mem_rd || rec.io_rd)) begin
                    rec.mem_rd = 1'b1;
                    rec.raddr  = addr;
                    rec.rdata  = data;
                end else if (!rec.mem_rd2) begin
                    rec.mem_rd2 = 1'b1;
                    rec.raddr2  = addr;
                    rec.rdata2  = data;
                end else begin
                    rec.err = 1'b1;
                end
            end
            3'd2: begin
                if (!(rec.mem_wr || rec.io_wr)) begin
                    rec.mem_wr = 1'b1;
                    rec.waddr  = addr;
                    rec.wdata  = data;
                end else if (!rec.mem_wr2) begin
                    rec.mem_wr2 = 1'b1;
                    rec.waddr2  = addr;
                    rec.wdata2  = data;
                end else begin
                    rec.err = 1'b1;
                end
            end
            3'd3: begin
                if (!(rec.mem_rd || rec.io_rd)) begin
                    rec.io_rd = 1'b1;
                    rec.raddr = addr;
                    rec.rdata = data;
                end else begin
                    rec.err = 1'b1;
                end
            end
            3'd4: begin
                if (!(rec.mem_wr || rec.io_wr)) begin
                    rec.io_wr = 1'b1;
                    rec.waddr = addr;
                    rec.wdata = data;
                end else begin
                    rec.err = 1'b1;
                end
            end
            default: ;
        endcase
        return rec;
    endfunction

    state_t         r_state;
    state_t         w_state_next;
    rec_t           r_work;
    logic [209:0]   r_regs_in;
    logic [15:0]    r_order;

    logic           r_valid;
    rec_t           r_out_rec;
    logic [209:0]   r_out_regs_in;
    logic [209:0]   r_out_regs_out;
    logic [15:0]    r_out_order;

    logic           w_evt_hit;
    logic           w_retire;
    rec_t           w_cur_upd;
    rec_t           w_new_rec;

    // An event on an i_insn_start cycle belongs to the new instruction.
    // Otherwise it belongs to the open one, including on its retire cycle.
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_evt_hit    = i_bus_evt_valid && ((r_state == CAPTURE) || i_insn_start);
        w_retire     = (r_state == CAPTURE) && i_insn_done;
        w_cur_upd    = r_work;
        w_new_rec    = REC_ZERO;
        w_state_next = r_state;

        if (w_evt_hit && !i_insn_start) begin
            w_cur_upd = apply_evt(r_work, i_bus_evt_kind, i_bus_evt_addr, i_bus_evt_data);
        end
        if (w_evt_hit && i_insn_start) begin
            w_new_rec = apply_evt(REC_ZERO, i_bus_evt_kind, i_bus_evt_addr, i_bus_evt_data);
        end

        if (i_insn_start) begin
            w_state_next = CAPTURE;
        end else if (w_retire) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_work         <= REC_ZERO;
            r_regs_in      <= '0;
            r_order        <= '0;
            r_valid        <= 1'b0;
            r_out_rec      <= REC_ZERO;
            r_out_regs_in  <= '0;
            r_out_regs_out <= '0;
            r_out_order    <= '0;
        end else begin
            r_valid <= w_retire;

            if (w_retire) begin
                r_out_rec      <= w_cur_upd;
                r_out_regs_in  <= r_regs_in;
                r_out_regs_out <= i_core_regs;
                r_out_order    <= r_order;
                r_order        <= r_order + 16'd1;
            end

            if (i_insn_start) begin
                r_regs_in <= i_core_regs;
                r_work    <= w_new_rec;
            end else if (r_state == CAPTURE) begin
                r_work <= w_cur_upd;
            end
        end
    end

    assign o_z80fi_valid    = r_valid;
    assign o_z80fi_order    = r_out_order;
    assign o_z80fi_regs_in  = r_out_regs_in;
    assign o_z80fi_regs_out = r_out_regs_out;
    assign o_z80fi_insn     = r_out_rec.insn;
    assign o_z80fi_insn_len = r_out_rec.len;
    assign o_mem_rd         = r_out_rec.mem_rd;
    assign o_mem_rd2        = r_out_rec.mem_rd2;
    assign o_mem_wr         = r_out_rec.mem_wr;
    assign o_mem_wr2        = r_out_rec.mem_wr2;
    assign o_io_rd          = r_out_rec.io_rd;
    assign o_io_wr          = r_out_rec.io_wr;
    assign o_bus_raddr      = r_out_rec.raddr;
    assign o_bus_raddr2     = r_out_rec.raddr2;
    assign o_bus_waddr      = r_out_rec.waddr;
    assign o_bus_waddr2     = r_out_rec.waddr2;
    assign o_bus_rdata      = r_out_rec.rdata;
    assign o_bus_rdata2     = r_out_rec.rdata2;
    assign o_bus_wdata      = r_out_rec.wdata;
    assign o_bus_wdata2     = r_out_rec.wdata2;
    assign o_z80fi_error    = r_out_rec.err;

endmodule

// File: doc/z80fi_trace_gen.md
# z80fi_trace_gen

Producer side of the Z80FI formal interface: observes the core's instruction boundaries, bus events and architectural register file, and emits one Z80FI trace record per retired instruction. The record carries the pre-state and post-state registers, memory/I/O transaction slots and the instruction bytes. It sits between the CPU core and the Z80FI instruction checkers, which consume `z80fi_valid` plus the record fields.

## Interface
- `MAX_INSN_BYTES`, 4, capacity of the instruction-byte capture buffer (fixed at 4; other values unsupported)
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `insn_start`  in  1  core begins an instruction this cycle (first M1)
- `insn_done`  in  1  core retires the current instruction this cycle
- `core_regs`  in  210  live architectural state, packed MSB-first: ip[16], a,f,b,c,d,e,h,l[8 each], a2,f2,b2,c2,d2,e2,h2,l2[8 each], ix,iy,sp[16 each], i,r[8 each], iff1, iff2
- `bus_evt_valid`  in  1  a bus transaction completes this cycle
- `bus_evt_kind`  in  3  0 fetch, 1 mem read, 2 mem write, 3 io read, 4 io write, 5–7 ignored
- `bus_evt_addr`  in  16  transaction address
- `bus_evt_data`  in  8  transaction data
- `z80fi_valid`  out  1  one-cycle strobe: record fields are a complete retired instruction
- `z80fi_order`  out  16  retire count of this record, wraps 0xFFFF→0x0000
- `z80fi_regs_in` / `z80fi_regs_out`  out  210 each  state at `insn_start` / at `insn_done`, same packing
- `z80fi_insn`  out  32  fetched bytes, first byte in [7:0]; unused bytes 0
- `z80fi_insn_len`  out  3  number of fetch events captured (0–4)
- `mem_rd`, `mem_rd2`, `mem_wr`, `mem_wr2`, `io_rd`, `io_wr`  out  1 each  slot-used flags
- `bus_raddr`, `bus_raddr2`, `bus_waddr`, `bus_waddr2`  out  16 each
- `bus_rdata`, `bus_rdata2`, `bus_wdata`, `bus_wdata2`  out  8 each
- `z80fi_error`  out  1  record overflowed a slot or the byte buffer

## Operation
- FSM states: IDLE (reset; no instruction open), CAPTURE (instruction open). `insn_start` in any state → CAPTURE, latch `core_regs` into working pre-state, clear working slots, byte buffer, length and error.
- `insn_done` in IDLE: ignored. In CAPTURE: latch `core_regs` as post-state, publish working record to outputs, increment order, emit `z80fi_valid` next cycle. Go to IDLE unless `insn_start` is also asserted, in which case reopen CAPTURE for the next instruction.
- `insn_start` in CAPTURE without `insn_done`: open instruction discarded; no record, order unchanged.
- Bus events are accepted only in CAPTURE (or on the `insn_start` cycle). An event on an `insn_done` cycle belongs to the retiring instruction, unless `insn_start` is also asserted, in which case it belongs to the new one.
- Fetch: byte appended at index len; len increments. 5th+ fetch sets error, byte dropped, len saturates at 4.
- Mem read: fills slot 1 (`mem_rd`, `bus_raddr`, `bus_rdata`) if free, else slot 2 (`mem_rd2`…). Third read sets error, dropped.
- Mem write: same rule on the write slots 1/2.
- IO read: uses read slot 1 and sets `io_rd`; if read slot 1 is already used, sets error. IO write: uses write slot 1 and sets `io_wr`; same conflict rule.
- Kinds 5–7 and events in IDLE: no effect.
- The record published on a `z80fi_valid` cycle also reflects a same-cycle event that the rules above assign to the retiring instruction.

## Timing
- `z80fi_valid` asserted exactly one cycle after the `insn_done` cycle, for one cycle. All record outputs are registered, change only on that cycle, and hold until the next record.
- Back-to-back retires (`insn_done` on consecutive cycles with `insn_start` overlapping) produce consecutive `z80fi_valid` pulses with no lost records.
- `z80fi_order` of the first record after reset = 0.
- Reset: every output 0, FSM IDLE, working record and order cleared. Reset mid-CAPTURE discards the open instruction. Reset coincident with `insn_done` emits no record.

## Test plan
- Start with ip=0x0100, fetch 0x3E, 0x42, done with a=0x42, ip=0x0102 → next-cycle valid, insn=0x0000423E, len=2, regs_in.ip=0x0100, regs_out.a=0x42, order=0, no slot flags.
- LD (HL),A: fetch 0x77, mem write addr 0x8000 data 0x55 → mem_wr=1, waddr=0x8000, wdata=0x55, mem_wr2=0, error=0.
- EX (SP),HL style: reads at 0xFFF0 and 0xFFF1, writes at 0xFFF1 and 0xFFF0 → both read and both write slots filled, in event order.
- Three mem reads in one instruction → error=1, slot 2 holds the second read.
- insn_done with insn_start on same cycle, repeated 3 times → 3 consecutive valid pulses, order 0,1,2, each regs_in equal to the prior regs_out.
- Reset asserted mid-CAPTURE, then done → no valid; all outputs 0; next record has order 0.
